// File: rtl/mem_port_arbiter_if.sv
// Bundle of the arbiter's fetch, data and memory-side signals.
// master: the environment (core fetch/LSU plus the memory slave); slave: the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
);
    // Instruction fetch side
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          if_err;

    // Load/store side
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [1:0]    d_size;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_err;

    // Memory side
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_size;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_size,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size
    );

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_size,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// One outstanding transaction, D-priority with an IF anti-starvation limit,
// and a response timeout so a dead slave cannot hang the core.
// Memory requests and responses pass through combinationally (zero added latency),
// so outputs are decoded from state and inputs and forced to 0 while rst_n is low.
module mem_port_arbiter #(
    parameter int unsigned AW          = 64,
    parameter int unsigned DW          = 64,
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam int unsigned SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam int unsigned TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    // Fetches always use the full bus width
    localparam logic [1:0] IF_SIZE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t        r_state;
    logic          r_sel;       // owner: 1 = D, 0 = IF
    logic          r_we;        // owner's transaction is a store
    logic [SW-1:0] r_dstreak;
    logic [TW-1:0] r_timer;

    state_t        w_next;
    logic          w_any;
    logic          w_win_d;
    logic          w_own_d;
    logic          w_timeout;
    logic          w_mem_req;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic [1:0]    w_mem_size;
    logic          w_gnt;
    logic          w_rvalid;
    logic          w_err;
    logic [DW-1:0] w_rdata;

    assign w_any     = bus.if_req | bus.d_req;
    assign w_win_d   = bus.d_req & ~(bus.if_req & (r_dstreak == STREAK_MAX));
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_timer == TIMER_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch owner at arbitration and track the consecutive-D streak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel     <= 1'b0;
            r_we      <= 1'b0;
            r_dstreak <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_sel <= w_win_d;
            r_we  <= w_win_d & bus.d_we;
            if (!w_win_d) begin
                r_dstreak <= '0;
            end else if (r_dstreak != STREAK_MAX) begin
                r_dstreak <= r_dstreak + 1'b1;
            end
        end
    end

    // Response timer: restarts on every state change, counts in WAIT and DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_next != r_state) begin
            r_timer <= '0;
        end else if (r_state == S_WAIT || r_state == S_DRAIN) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Next state and owner-relative handshake decode
    always_comb begin
        w_next      = r_state;
        w_own_d     = r_sel;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_size  = 2'd0;
        w_gnt       = 1'b0;
        w_rvalid    = 1'b0;
        w_err       = 1'b0;
        w_rdata     = '0;

        case (r_state)
            S_IDLE: begin
                w_own_d = w_win_d;
                if (w_any) begin
                    w_mem_req = 1'b1;
                    w_gnt     = bus.mem_gnt;
                    w_next    = bus.mem_gnt ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                w_mem_req = 1'b1;
                if (bus.mem_gnt) begin
                    w_gnt  = 1'b1;
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_rvalid = 1'b1;
                    w_rdata  = r_we ? '0 : bus.mem_rdata;
                    w_next   = S_IDLE;
                end else if (w_timeout) begin
                    w_rvalid = 1'b1;
                    w_err    = 1'b1;
                    w_next   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The late response of the abandoned transaction is swallowed here
                if (bus.mem_rvalid || w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (w_mem_req) begin
            w_mem_we    = w_own_d & bus.d_we;
            w_mem_addr  = w_own_d ? bus.d_addr : bus.if_addr;
            w_mem_wdata = w_own_d ? bus.d_wdata : '0;
            w_mem_size  = w_own_d ? bus.d_size : IF_SIZE;
        end
    end

    // Route to the owner; everything reads 0 while reset is asserted
    assign bus.mem_req   = rst_n & w_mem_req;
    assign bus.mem_we    = rst_n & w_mem_we;
    assign bus.mem_addr  = rst_n ? w_mem_addr : '0;
    assign bus.mem_wdata = rst_n ? w_mem_wdata : '0;
    assign bus.mem_size  = rst_n ? w_mem_size : 2'd0;

    assign bus.if_gnt    = rst_n & w_gnt & ~w_own_d;
    assign bus.if_rvalid = rst_n & w_rvalid & ~w_own_d;
    assign bus.if_err    = rst_n & w_err & ~w_own_d;
    assign bus.if_rdata  = (rst_n && !w_own_d) ? w_rdata : '0;

    assign bus.d_gnt     = rst_n & w_gnt & w_own_d;
    assign bus.d_rvalid  = rst_n & w_rvalid & w_own_d;
    assign bus.d_err     = rst_n & w_err & w_own_d;
    assign bus.d_rdata   = (rst_n && w_own_d) ? w_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF) and the load/store unit (D).
- D access parameters come straight from the control-unit decode: write strobe from the memrw decode, size from inst[13:12].
- Sequences one outstanding transaction at a time. Arbitration is D-priority with an anti-starvation limit for IF.
- A response timeout returns an error to the owner so a dead slave cannot hang the core.

Parameters:
AW, 64, address width
DW, 64, data width
MAX_DSTREAK, 4, consecutive D grants allowed while IF is waiting before IF is forced
TIMEOUT_CYC, 255, cycles in WAIT without mem_rvalid before error; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held stable until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  fetch accepted by memory
if_rvalid  out  1  fetch response valid
if_rdata  out  DW  fetch data
if_err  out  1  fetch timed out (qualifies if_rvalid)
d_req  in  1  data request; held stable until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_size  in  2  0=byte 1=half 2=word 3=dword
d_gnt  out  1  data accepted
d_rvalid  out  1  load data / store ack valid
d_rdata  out  DW  load data
d_err  out  1  data timed out
mem_req  out  1  request to memory
mem_we  out  1  write
mem_addr  out  AW  address
mem_wdata  out  DW  write data
mem_size  out  2  access size
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  response (reads and writes)
mem_rdata  in  DW  read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; sel, dstreak and timer cleared.
  - All outputs 0.
  - Any in-flight transaction is abandoned; a late mem_rvalid after reset is ignored.
- States: IDLE, REQ, WAIT, DRAIN.
- Arbitration (IDLE only):
  - Both requesting: grant D unless dstreak==MAX_DSTREAK, then grant IF.
  - A D grant increments dstreak (saturating). An IF grant clears dstreak. D requesting alone does not clear it.
- IDLE:
  - If any request, the winner's fields drive mem_* combinationally and mem_req=1 in the same cycle.
  - sel is latched.
  - mem_gnt=1 in that cycle: pulse winner's gnt, go to WAIT. Otherwise go to REQ.
- REQ:
  - mem_req=1 with the latched sel; selection must not change.
  - On mem_gnt: pulse gnt to the owner, go to WAIT.
- WAIT:
  - mem_req=0; timer increments each cycle.
  - On mem_rvalid: owner's rvalid=1 and rdata=mem_rdata (zero added latency), err=0; go to IDLE. The next request is presented the following cycle.
  - If TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1 with no mem_rvalid: owner's rvalid=1, err=1, rdata=0; go to DRAIN.
- DRAIN:
  - mem_req=0; timer restarts.
  - First mem_rvalid is discarded, then go to IDLE.
  - Also returns to IDLE after TIMEOUT_CYC cycles.
- Gating:
  - if_rdata/d_rdata are 0 except in their own rvalid cycle.
  - gnt, rvalid and err are single-cycle pulses.
  - Exactly one of if_rvalid/d_rvalid per transaction.
- mem_rvalid outside WAIT/DRAIN is ignored.
- mem_gnt and mem_rvalid together in REQ are not legal memory behaviour; rvalid is ignored there.
- Stores complete on mem_rvalid (ack); d_rdata is 0 for stores.

Test Plan:
- IF only, addr=0x1000; mem_gnt same cycle, mem_rvalid 2 cycles later with 0xDEAD -> mem_req 1 cycle, if_gnt cycle 0, if_rvalid cycle 2 with if_rdata=0xDEAD, if_err=0.
- if_req and d_req (load 0x2000, size=3) together, mem_gnt delayed 3 cycles -> mem_addr held 0x2000 through REQ; d_gnt on cycle 3; IF is served next after d_rvalid.
- if_req held while d_req continuously asserted with MAX_DSTREAK=4 -> exactly 4 D transactions, then one IF transaction, then D resumes.
- Store d_we=1, d_wdata=0x55, size=0 -> mem_we=1, mem_wdata=0x55, mem_size=0; ack gives d_rvalid=1, d_rdata=0.
- TIMEOUT_CYC=8, no mem_rvalid -> d_rvalid=1, d_err=1 on the 8th WAIT cycle. A late mem_rvalid in DRAIN produces no rvalid pulse; the next request is granted normally.
- rst_n pulsed low during WAIT -> all outputs 0 immediately; a stale mem_rvalid after release produces no rvalid; the next if_req is served from IDLE.
